// File: rtl/axi_ic_defines.sv
// Shared definitions for the 1-master / 2-slave AXI interconnect.
// Holds the write-router state encoding and the AXI response codes.
package axi_ic_defines;

    // Write-path router states. ST_IDLE must stay at encoding 0 so that the
    // debug state output reads 0 out of reset along with every other output.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR_DATA = 3'd4,
        ST_ERR_RESP = 3'd5
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_wr_addr_decoder.sv
// Combinational address decoder for the 1x2 interconnect.
// Ports:
//   addr : address to decode
//   sel  : 0 = slave 0 (below S1_BASE), 1 = slave 1 window
//   err  : address lies above S1_LIMIT (no slave owns it)
// Shared by the write router and the read router.
module axi_wr_addr_decoder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 'h0000_8000,
    parameter logic [ADDR_WIDTH-1:0] S1_LIMIT   = 'h0000_FFFF
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  sel,
    output logic                  err
);

    // Slave 0 owns everything below S1_BASE; anything at or above S1_BASE is
    // slave 1 unless it runs past S1_LIMIT.
    assign sel = (addr >= S1_BASE);
    assign err = sel && (addr > S1_LIMIT);

endmodule

// File: rtl/axi_wr_router.sv
// Write-path control stage for the 1-master / 2-slave AXI interconnect.
// Decodes AWADDR once per transaction, registers the slave select, and
// sequences AW -> W -> B handshakes to the selected slave. Out-of-range
// writes are absorbed locally and answered with DECERR.
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where both valid and ready are 1; valid/ready of the selected slave are
// passed straight through, the unselected slave sees 0 on all its controls.
// Ports:
//   ACLK, ARESET          : clock, async active-high reset
//   M_AW*/M_W*/M_B*       : master-side AW, W, B channel controls
//   S0_*/S1_*             : slave-side AW, W, B channel controls
//   wr_select             : registered demux select for AW/W payload steering
//   dbg_state             : current FSM state (wr_state_e encoding)
module axi_wr_router
    import axi_ic_defines::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 'h0000_8000,
    parameter logic [ADDR_WIDTH-1:0] S1_LIMIT   = 'h0000_FFFF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] M_AWADDR,
    input  logic                  M_AWVALID,
    output logic                  M_AWREADY,
    input  logic                  M_WVALID,
    input  logic                  M_WLAST,
    output logic                  M_WREADY,
    output logic                  M_BVALID,
    input  logic                  M_BREADY,
    output logic [1:0]            M_BRESP,
    output logic                  S0_AWVALID,
    output logic                  S1_AWVALID,
    input  logic                  S0_AWREADY,
    input  logic                  S1_AWREADY,
    output logic                  S0_WVALID,
    output logic                  S1_WVALID,
    input  logic                  S0_WREADY,
    input  logic                  S1_WREADY,
    input  logic                  S0_BVALID,
    input  logic                  S1_BVALID,
    output logic                  S0_BREADY,
    output logic                  S1_BREADY,
    input  logic [1:0]            S0_BRESP,
    input  logic [1:0]            S1_BRESP,
    output logic                  wr_select,
    output logic [2:0]            dbg_state
);

    wr_state_e state_q, state_d;
    logic      sel_q, sel_d;
    logic      dec_sel, dec_err;

    // Selected-slave views of the inputs, so the FSM reads one set of names.
    logic       aw_ready_sel, w_ready_sel, b_valid_sel;
    logic [1:0] b_resp_sel;

    axi_wr_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .S1_BASE    (S1_BASE),
        .S1_LIMIT   (S1_LIMIT)
    ) u_dec (
        .addr (M_AWADDR),
        .sel  (dec_sel),
        .err  (dec_err)
    );

    assign aw_ready_sel = sel_q ? S1_AWREADY : S0_AWREADY;
    assign w_ready_sel  = sel_q ? S1_WREADY  : S0_WREADY;
    assign b_valid_sel  = sel_q ? S1_BVALID  : S0_BVALID;
    assign b_resp_sel   = sel_q ? S1_BRESP   : S0_BRESP;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        M_AWREADY  = 1'b0;
        M_WREADY   = 1'b0;
        M_BVALID   = 1'b0;
        M_BRESP    = RESP_OKAY;
        S0_AWVALID = 1'b0;
        S1_AWVALID = 1'b0;
        S0_WVALID  = 1'b0;
        S1_WVALID  = 1'b0;
        S0_BREADY  = 1'b0;
        S1_BREADY  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The error-path accept is the only IDLE output; it is held
                // off while reset is asserted so every output reads 0 then.
                if (M_AWVALID && !ARESET) begin
                    if (dec_err) begin
                        // wr_select keeps its old value on a decode error.
                        M_AWREADY = 1'b1;
                        state_d   = ST_ERR_DATA;
                    end else begin
                        sel_d   = dec_sel;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                // A dropped M_AWVALID just stalls here; no abort.
                S0_AWVALID = M_AWVALID && !sel_q;
                S1_AWVALID = M_AWVALID &&  sel_q;
                M_AWREADY  = aw_ready_sel;
                if (M_AWVALID && aw_ready_sel) state_d = ST_DATA;
            end
            ST_DATA: begin
                S0_WVALID = M_WVALID && !sel_q;
                S1_WVALID = M_WVALID &&  sel_q;
                M_WREADY  = w_ready_sel;
                if (M_WVALID && w_ready_sel && M_WLAST) state_d = ST_RESP;
            end
            ST_RESP: begin
                M_BVALID  = b_valid_sel;
                M_BRESP   = b_resp_sel;
                S0_BREADY = M_BREADY && !sel_q;
                S1_BREADY = M_BREADY &&  sel_q;
                if (b_valid_sel && M_BREADY) state_d = ST_IDLE;
            end
            ST_ERR_DATA: begin
                // Sink the burst locally; no slave is involved.
                M_WREADY = 1'b1;
                if (M_WVALID && M_WLAST) state_d = ST_ERR_RESP;
            end
            ST_ERR_RESP: begin
                M_BVALID = 1'b1;
                M_BRESP  = RESP_DECERR;
                if (M_BREADY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_select = sel_q;
    assign dbg_state = state_q;

endmodule
